// File: rtl/nx_instr_fetch_if.sv
// rtl/nx_instr_fetch_if.sv - store read port and core instruction stream bundle
interface nx_instr_fetch_if #(
  parameter int INSTR_WIDTH = 15,
  parameter int ADDR_W      = 9
);
  logic [ADDR_W-1:0]      store_addr_o;
  logic                   store_rd_o;
  logic                   store_stall_i;
  logic [INSTR_WIDTH-1:0] store_data_i;
  logic [INSTR_WIDTH-1:0] instr_data_o;
  logic                   instr_valid_o;
  logic                   instr_last_o;
  logic                   instr_ready_i;

  modport master (
    output store_addr_o, store_rd_o,
    input  store_stall_i, store_data_i,
    output instr_data_o, instr_valid_o, instr_last_o,
    input  instr_ready_i
  );

  modport slave (
    input  store_addr_o, store_rd_o,
    output store_stall_i, store_data_i,
    input  instr_data_o, instr_valid_o, instr_last_o,
    output instr_ready_i
  );
endinterface

// File: rtl/nx_instr_fetch.sv
// rtl/nx_instr_fetch.sv - walks the instruction store 0..count-1 and streams words to decode
module nx_instr_fetch #(
  parameter int INSTR_WIDTH = 15,
  parameter int MAX_INSTRS  = 512,
  parameter int FIFO_DEPTH  = 2,
  localparam int ADDR_W     = $clog2(MAX_INSTRS)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                trigger_i,
  input  logic [ADDR_W-1:0]   populated_i,
  output logic                idle_o,
  nx_instr_fetch_if.master    bus
);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int OCC_W = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN} state_t;

  state_t                 state;
  logic [ADDR_W-1:0]      count;
  logic [ADDR_W-1:0]      addr;
  logic                   in_flight;
  logic                   in_flight_last;
  logic [INSTR_WIDTH-1:0] fifo_data [FIFO_DEPTH];
  logic                   fifo_last [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       rd_ptr;
  logic [OCC_W-1:0]       occ;

  logic fifo_valid;
  logic pop;
  logic push;
  logic credit_ok;
  logic rd_req;
  logic accept;
  logic is_last_addr;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // A request may only go out if its response is guaranteed a FIFO slot,
  // counting the entry the core is draining this very cycle.
  always_comb begin
    fifo_valid   = (occ != '0);
    pop          = fifo_valid && bus.instr_ready_i;
    push         = in_flight;
    credit_ok    = ({1'b0, occ} + (OCC_W+1)'(in_flight))
                   < ((OCC_W+1)'(FIFO_DEPTH) + (OCC_W+1)'(pop));
    rd_req       = (state == S_FETCH) && credit_ok;
    accept       = rd_req && !bus.store_stall_i;
    is_last_addr = (addr == count - ADDR_W'(1));
  end

  assign idle_o            = (state == S_IDLE);
  assign bus.store_rd_o    = rd_req;
  assign bus.store_addr_o  = (state == S_FETCH) ? addr : '0;
  assign bus.instr_valid_o = fifo_valid;
  assign bus.instr_data_o  = fifo_valid ? fifo_data[rd_ptr] : '0;
  assign bus.instr_last_o  = fifo_valid && fifo_last[rd_ptr];

  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_data[wr_ptr] <= bus.store_data_i;
      fifo_last[wr_ptr] <= in_flight_last;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state          <= S_IDLE;
      count          <= '0;
      addr           <= '0;
      in_flight      <= 1'b0;
      in_flight_last <= 1'b0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      occ            <= '0;
    end else begin
      in_flight      <= accept;
      in_flight_last <= accept && is_last_addr;

      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({push, pop})
        2'b10:   occ <= occ + OCC_W'(1);
        2'b01:   occ <= occ - OCC_W'(1);
        default: occ <= occ;
      endcase

      case (state)
        S_IDLE: begin
          if (trigger_i && (populated_i != '0)) begin
            count <= populated_i;
            addr  <= '0;
            state <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (accept) begin
            addr <= addr + ADDR_W'(1);
            if (is_last_addr) state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          // Leaving on the last-tagged pop lets idle_o rise the very next cycle.
          if ((pop && fifo_last[rd_ptr]) || (!fifo_valid && !in_flight))
            state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_nx_instr_fetch.sv
// tb/tb_nx_instr_fetch.sv - scoreboard bench for nx_instr_fetch
module tb_nx_instr_fetch;
  localparam int IW = 15;
  localparam int MI = 512;
  localparam int FD = 2;
  localparam int AW = $clog2(MI);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          trigger;
  logic [AW-1:0] populated;
  logic          idle;

  nx_instr_fetch_if #(.INSTR_WIDTH(IW), .ADDR_W(AW)) bus ();

  nx_instr_fetch #(.INSTR_WIDTH(IW), .MAX_INSTRS(MI), .FIFO_DEPTH(FD)) dut (
    .clk_i       (clk),
    .rst_i       (rst_n),
    .trigger_i   (trigger),
    .populated_i (populated),
    .idle_o      (idle),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad   = 0;
  int          seed  = 0;
  int          pop_cnt = 0;
  logic [IW:0] exp_q [$];
  int          acc_q [$];
  logic [IW:0] mon_e;

  function automatic logic [IW-1:0] store_word(input int a, input int s);
    return IW'(a * 13 + s * 101 + 7);
  endfunction

  always @(posedge clk)
    if (bus.store_rd_o && !bus.store_stall_i)
      bus.store_data_i <= store_word(int'(bus.store_addr_o), seed);

  task automatic start_pass(input int n, input int s);
    seed = s;
    populated = AW'(n);
    trigger = 1'b1;
    for (int i = 0; i < n; i++) exp_q.push_back({(i == n - 1), store_word(i, s)});
    @(posedge clk); #1;
    trigger = 1'b0;
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (idle) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset;
    total++;
    if ({idle, bus.store_rd_o, bus.instr_valid_o, bus.instr_last_o} !== 4'b1000) begin
      bad++; $display("FAIL reset_flags got=%b expected=1000",
        {idle, bus.store_rd_o, bus.instr_valid_o, bus.instr_last_o});
    end
    total++;
    if ({bus.store_addr_o, bus.instr_data_o} !== '0) begin
      bad++; $display("FAIL reset_busses got addr=%h data=%h expected=0", bus.store_addr_o, bus.instr_data_o);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic;
    bus.instr_ready_i = 1'b1;
    acc_q.delete(); pop_cnt = 0;
    start_pass(4, 3);
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (k == 1) begin
        total++;
        if (idle !== 1'b0) begin bad++; $display("FAIL basic_idle_fall got=%b expected=0", idle); end
      end
      if (k <= 4) begin
        total++;
        if ({bus.store_rd_o, bus.store_addr_o} !== {1'b1, AW'(k - 1)}) begin
          bad++; $display("FAIL basic_req T+%0d got rd=%b addr=%0d expected rd=1 addr=%0d",
            k, bus.store_rd_o, bus.store_addr_o, k - 1);
        end
      end
      total++;
      if (bus.instr_valid_o !== (k >= 3 && k <= 6)) begin
        bad++; $display("FAIL basic_valid T+%0d got=%b expected=%b", k, bus.instr_valid_o, (k >= 3 && k <= 6));
      end
      total++;
      if (bus.instr_last_o !== (k == 6)) begin
        bad++; $display("FAIL basic_last T+%0d got=%b expected=%b", k, bus.instr_last_o, (k == 6));
      end
      if (k == 7) begin
        total++;
        if (idle !== 1'b1) begin bad++; $display("FAIL basic_idle_rise got=%b expected=1", idle); end
      end
    end
    @(posedge clk); #1;
    total++;
    if (pop_cnt != 4 || exp_q.size() != 0) begin
      bad++; $display("FAIL basic_count got pops=%0d left=%0d expected pops=4 left=0", pop_cnt, exp_q.size());
    end
  endtask

  task automatic test_backpressure;
    logic [IW-1:0] head;
    bit ok;
    bus.instr_ready_i = 1'b0;
    acc_q.delete(); pop_cnt = 0;
    head = '0;
    start_pass(6, 5);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 3) head = bus.instr_data_o;
    end
    total++;
    if (acc_q.size() != FD) begin
      bad++; $display("FAIL bp_accepts got=%0d expected=%0d", acc_q.size(), FD);
    end
    total++;
    if (bus.store_rd_o !== 1'b0) begin bad++; $display("FAIL bp_rd_low got=%b expected=0", bus.store_rd_o); end
    total++;
    if (head !== store_word(0, 5) || bus.instr_data_o !== store_word(0, 5) || bus.instr_valid_o !== 1'b1) begin
      bad++; $display("FAIL bp_head_stable got first=%h now=%h valid=%b expected=%h valid=1",
        head, bus.instr_data_o, bus.instr_valid_o, store_word(0, 5));
    end
    @(posedge clk); #1;
    bus.instr_ready_i = 1'b1;
    wait_idle(ok);
    total++;
    if (!ok) begin bad++; $display("FAIL bp_timeout got idle=%b expected=1", idle); end
    @(posedge clk); #1;
    total++;
    if (pop_cnt != 6 || exp_q.size() != 0) begin
      bad++; $display("FAIL bp_count got pops=%0d left=%0d expected pops=6 left=0", pop_cnt, exp_q.size());
    end
    for (int i = 0; i < acc_q.size(); i++) begin
      total++;
      if (acc_q[i] != i) begin bad++; $display("FAIL bp_addr_seq idx=%0d got=%0d expected=%0d", i, acc_q[i], i); end
    end
  endtask

  task automatic test_stall;
    bit ok;
    bus.instr_ready_i = 1'b1;
    acc_q.delete(); pop_cnt = 0;
    start_pass(3, 7);
    @(negedge clk);
    total++;
    if ({bus.store_rd_o, bus.store_addr_o} !== {1'b1, AW'(0)}) begin
      bad++; $display("FAIL stall_first got rd=%b addr=%0d expected rd=1 addr=0", bus.store_rd_o, bus.store_addr_o);
    end
    @(posedge clk); #1;
    bus.store_stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if ({bus.store_rd_o, bus.store_addr_o} !== {1'b1, AW'(1)}) begin
        bad++; $display("FAIL stall_hold cyc=%0d got rd=%b addr=%0d expected rd=1 addr=1",
          i, bus.store_rd_o, bus.store_addr_o);
      end
      if (i < 2) begin @(posedge clk); #1; end
    end
    @(posedge clk); #1;
    bus.store_stall_i = 1'b0;
    wait_idle(ok);
    total++;
    if (!ok) begin bad++; $display("FAIL stall_timeout got idle=%b expected=1", idle); end
    @(posedge clk); #1;
    total++;
    if (acc_q.size() != 3 || pop_cnt != 3 || exp_q.size() != 0) begin
      bad++; $display("FAIL stall_count got acc=%0d pops=%0d left=%0d expected 3 3 0",
        acc_q.size(), pop_cnt, exp_q.size());
    end
    for (int i = 0; i < acc_q.size(); i++) begin
      total++;
      if (acc_q[i] != i) begin bad++; $display("FAIL stall_addr_seq idx=%0d got=%0d expected=%0d", i, acc_q[i], i); end
    end
  endtask

  task automatic test_zero;
    bit idle_drop, rd_seen;
    idle_drop = 1'b0; rd_seen = 1'b0;
    acc_q.delete(); pop_cnt = 0;
    start_pass(0, 9);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (!idle) idle_drop = 1'b1;
      if (bus.store_rd_o) rd_seen = 1'b1;
    end
    total++;
    if (idle_drop !== 1'b0) begin bad++; $display("FAIL zero_idle got drop=%b expected=0", idle_drop); end
    total++;
    if (rd_seen !== 1'b0) begin bad++; $display("FAIL zero_rd got seen=%b expected=0", rd_seen); end
  endtask

  task automatic test_reset_midpass;
    bit ok;
    bus.instr_ready_i = 1'b1;
    acc_q.delete(); pop_cnt = 0;
    start_pass(8, 11);
    ok = 1'b0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (pop_cnt >= 2) begin ok = 1'b1; break; end
    end
    total++;
    if (!ok) begin bad++; $display("FAIL rst_wait got pops=%0d expected>=2", pop_cnt); end
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({idle, bus.store_rd_o, bus.instr_valid_o, bus.instr_last_o} !== 4'b1000) begin
      bad++; $display("FAIL rst_async_flags got=%b expected=1000",
        {idle, bus.store_rd_o, bus.instr_valid_o, bus.instr_last_o});
    end
    total++;
    if ({bus.store_addr_o, bus.instr_data_o} !== '0) begin
      bad++; $display("FAIL rst_async_busses got addr=%h data=%h expected=0", bus.store_addr_o, bus.instr_data_o);
    end
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    acc_q.delete(); pop_cnt = 0;
    start_pass(2, 13);
    wait_idle(ok);
    total++;
    if (!ok) begin bad++; $display("FAIL rst_restart_timeout got idle=%b expected=1", idle); end
    @(posedge clk); #1;
    total++;
    if (acc_q.size() != 2 || pop_cnt != 2 || exp_q.size() != 0) begin
      bad++; $display("FAIL rst_restart_count got acc=%0d pops=%0d left=%0d expected 2 2 0",
        acc_q.size(), pop_cnt, exp_q.size());
    end
    for (int i = 0; i < acc_q.size(); i++) begin
      total++;
      if (acc_q[i] != i) begin bad++; $display("FAIL rst_addr_seq idx=%0d got=%0d expected=%0d", i, acc_q[i], i); end
    end
  endtask

  task automatic test_ignore;
    bit ok;
    bus.instr_ready_i = 1'b1;
    acc_q.delete(); pop_cnt = 0;
    start_pass(4, 15);
    @(posedge clk); #1;
    trigger = 1'b1;
    populated = AW'(9);
    repeat (2) @(posedge clk);
    #1;
    trigger = 1'b0;
    wait_idle(ok);
    total++;
    if (!ok) begin bad++; $display("FAIL ignore_timeout got idle=%b expected=1", idle); end
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (acc_q.size() != 4 || pop_cnt != 4 || exp_q.size() != 0 || idle !== 1'b1) begin
      bad++; $display("FAIL ignore_count got acc=%0d pops=%0d left=%0d idle=%b expected 4 4 0 1",
        acc_q.size(), pop_cnt, exp_q.size(), idle);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    trigger = 1'b0;
    populated = '0;
    bus.store_stall_i = 1'b0;
    bus.instr_ready_i = 1'b0;
    fork
      forever begin
        @(negedge clk);
        if (rst_n && bus.store_rd_o && !bus.store_stall_i) acc_q.push_back(int'(bus.store_addr_o));
        if (rst_n && bus.instr_valid_o && bus.instr_ready_i) begin
          pop_cnt++;
          total++;
          if (exp_q.size() == 0) begin
            bad++; $display("FAIL pop_unexpected got last=%b data=%h expected=none", bus.instr_last_o, bus.instr_data_o);
          end else begin
            mon_e = exp_q.pop_front();
            if ({bus.instr_last_o, bus.instr_data_o} !== mon_e) begin
              bad++; $display("FAIL pop_data got last=%b data=%h expected last=%b data=%h",
                bus.instr_last_o, bus.instr_data_o, mon_e[IW], mon_e[IW-1:0]);
            end
          end
        end
      end
    join_none
    repeat (3) @(posedge clk);
    #1;
    test_reset;
    test_basic;
    test_backpressure;
    test_stall;
    test_zero;
    test_reset_midpass;
    test_ignore;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/nx_instr_fetch.md
# nx_instr_fetch

Per-core instruction fetch unit that sits between one core's fetch port on the instruction store and the core's decode stage. On a trigger it walks the store from address 0 up to the populated count captured at the trigger, issuing read requests and obeying the store's stall. Returned instructions are buffered in a small FIFO and presented to the core over a valid/ready handshake, with the final instruction of the pass flagged.

## Interface
- INSTR_WIDTH, 15, instruction width in bits
- MAX_INSTRS, 512, store depth per core; ADDR_W = $clog2(MAX_INSTRS)
- FIFO_DEPTH, 2, output buffer entries; legal values 2 to 8
- clk_i  input  1  clock
- rst_i  input  1  reset; asynchronous and active-low (asserted at 0)
- trigger_i  input  1  start a fetch pass; sampled only in IDLE
- populated_i  input  ADDR_W  number of loaded instructions; sampled on an accepted trigger
- idle_o  output  1  high when no pass is in progress
- store_addr_o  output  ADDR_W  read address to the instruction store
- store_rd_o  output  1  read request
- store_stall_i  input  1  store refuses the request in the current cycle
- store_data_i  input  INSTR_WIDTH  read data; valid the cycle after an accepted request
- instr_data_o  output  INSTR_WIDTH  instruction to the core
- instr_valid_o  output  1  instr_data_o is valid
- instr_last_o  output  1  qualifies instr_valid_o; entry is address (count-1)
- instr_ready_i  input  1  core accepts the instruction

## Operation
- States are IDLE, FETCH and DRAIN. On reset: IDLE, idle_o=1, all other outputs 0, FIFO empty, in-flight count 0.
- IDLE: trigger_i=1 with populated_i!=0 latches count=populated_i, sets addr=0, and moves to FETCH. With populated_i==0 the trigger is ignored and the block stays in IDLE.
- FETCH: store_rd_o=1 only when the credit check passes: occupancy + in_flight − pop_this_cycle < FIFO_DEPTH.
- A request is accepted when store_rd_o=1 and store_stall_i=0. On acceptance addr increments and in_flight is set for one cycle.
- While stalled, store_addr_o and store_rd_o hold unchanged. The block never re-issues an accepted address and never skips an address.
- After the request for addr = count−1 is accepted, the state moves to DRAIN.
- DRAIN: no requests are issued. When the FIFO is empty and nothing is in flight, the state returns to IDLE.
- Each response is pushed to the FIFO with a last tag equal to (address == count−1). The FIFO head drives instr_data_o, instr_valid_o and instr_last_o.
- A pop occurs when instr_valid_o=1 and instr_ready_i=1. instr_data_o stays stable while instr_valid_o=1 and instr_ready_i=0.
- trigger_i outside IDLE is ignored. Changes to populated_i during a pass are ignored because count is latched.
- store_addr_o is 0 whenever store_rd_o=0 in IDLE.
- Width rules: count is ADDR_W bits, so a pass can cover at most MAX_INSTRS−1 instructions. The addr comparison must not wrap.
- Reset mid-pass: all state clears immediately and asynchronously. A store response arriving in the cycle after reset deasserts is discarded. The next trigger restarts from address 0.

## Timing
- Trigger sampled at edge T: FETCH is entered and store_rd_o=1 in cycle T+1.
- Response for the request accepted in cycle C arrives in C+1, is pushed at the end of C+1, and is visible on instr_valid_o in C+2.
- Unstalled path with instr_ready_i=1: first instruction valid at T+3. Sustained rate is one instruction per cycle for FIFO_DEPTH≥2.
- idle_o falls in the cycle after the trigger. It rises in the cycle after the pop of the last-tagged entry.
- Simultaneous push and pop in one cycle are both honoured, and occupancy is unchanged.

## Test plan
- populated_i=4, trigger at T, ready held 1, no stall:
  - store_addr_o 0,1,2,3 on T+1..T+4;
  - instr_valid_o on T+3..T+6 with data matching the store contents;
  - instr_last_o only at T+6;
  - idle_o=1 at T+7.
- populated_i=6 with ready held 0:
  - exactly FIFO_DEPTH requests accepted, then store_rd_o=0 and head data stable;
  - after ready rises, all 6 instructions delivered in order with none duplicated.
- populated_i=3 with store_stall_i=1 for 3 cycles while addr=1:
  - store_addr_o=1 and store_rd_o=1 held for the full stall;
  - output order is 0,1,2 with no repeats.
- populated_i=0 and trigger pulsed: idle_o stays 1 and store_rd_o never asserts.
- rst_i driven to 0 mid-pass after 2 instructions delivered:
  - all outputs 0 and idle_o=1 immediately, without waiting for a clock edge;
  - after release, a trigger with populated_i=2 fetches addresses 0,1 cleanly.
- Trigger re-pulsed and populated_i changed 4→9 during a pass: both are ignored and exactly 4 instructions are delivered.
